lnet_layer_sched: RTL and testbench

- Time-multiplexed evaluator for one LogicNets layer of 6-input, 1-output truth-table neurons.
- Replaces N hard-wired LUT neurons with one shared evaluation path, stepped one neuron per cycle.
- Truth tables and fan-in connectivity are runtime-programmable through a config port.
- Sits between layer N-1 output registers and layer N+1 input; valid/ready on both sides.

---
 rtl/lnet_pkg.sv | 19 +
 rtl/lnet_addr_gather.sv | 23 ++
 rtl/lnet_layer_sched.sv | 118 +++++++++++
 tb/tb_lnet_layer_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lnet_pkg.sv
// Shared types and constants for the time-multiplexed LogicNets layer evaluator.
// Index width is sized for the default 32-bit input feature vector.
package lnet_pkg;
  localparam int FAN_IN   = 6;
  localparam int ADDR_W   = FAN_IN;
  localparam int IN_W_DEF = 32;
  localparam int IDX_W    = $clog2(IN_W_DEF);

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  typedef logic [FAN_IN-1:0][IDX_W-1:0] idx_vec_t;

  // Field j selects input bit j: the connectivity a neuron has after reset.
  function automatic idx_vec_t identity_idx();
    idx_vec_t v;
    for (int j = 0; j < FAN_IN; j++) v[j] = IDX_W'(j);
    return v;
  endfunction
endpackage

// File: rtl/lnet_addr_gather.sv
// Builds one neuron's truth-table address from the latched input vector and
// its fan-in index set. Indices past the end of the vector read as 0.
module lnet_addr_gather
  import lnet_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic [IN_W-1:0]   vec,
  input  idx_vec_t          idx,
  output logic [ADDR_W-1:0] addr
);
  logic [2**IDX_W-1:0] ext;

  // Zero-extending to the full index range makes out-of-range indices select 0.
  always_comb begin
    ext = '0;
    ext[IN_W-1:0] = vec;
  end

  for (genvar gi = 0; gi < FAN_IN; gi++) begin : g_bit
    assign addr[gi] = ext[idx[gi]];
  end
endmodule

// File: rtl/lnet_layer_sched.sv
// One shared truth-table evaluation path stepped across all neurons of a layer,
// with runtime-programmable truth tables and fan-in connectivity.
module lnet_layer_sched
  import lnet_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int N_NEUR = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_NEUR-1:0]         out_data,
  input  logic                      cfg_tt_we,
  input  logic                      cfg_idx_we,
  input  logic [$clog2(N_NEUR)-1:0] cfg_neur,
  input  logic [2**FAN_IN-1:0]      cfg_tt,
  input  logic [FAN_IN*IDX_W-1:0]   cfg_idx,
  output logic                      busy
);
  localparam int NEUR_W = $clog2(N_NEUR);
  localparam int CNT_W  = $clog2(N_NEUR + 1);
  localparam int TT_W   = 2**FAN_IN;

  state_t              state_reg, state_next;
  logic [IN_W-1:0]     vec_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                rd_bit_reg, rd_v_reg;
  logic [NEUR_W-1:0]   rd_n_reg;
  logic [N_NEUR-1:0]   out_data_reg;

  logic [TT_W-1:0]     tt_rd  [N_NEUR];
  idx_vec_t            idx_rd [N_NEUR];

  logic                cfg_any, cfg_en, accept, eval_step;
  logic [NEUR_W-1:0]   cur_n;
  logic [ADDR_W-1:0]   addr;

  assign cfg_any   = cfg_tt_we | cfg_idx_we;
  assign cfg_en    = (state_reg == IDLE);
  assign accept    = in_valid & in_ready;
  assign eval_step = (state_reg == EVAL) && (cnt_reg != CNT_W'(N_NEUR));
  assign cur_n     = cnt_reg[NEUR_W-1:0];
  assign out_valid = (state_reg == OUT);
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;

  // Per-neuron table and index storage; config lands only while idle.
  for (genvar gi = 0; gi < N_NEUR; gi++) begin : g_neur
    logic [TT_W-1:0] tt_reg;
    idx_vec_t        idx_reg;
    logic            sel;

    assign sel        = cfg_en && (cfg_neur == NEUR_W'(gi));
    assign tt_rd[gi]  = tt_reg;
    assign idx_rd[gi] = idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tt_reg  <= '0;
        idx_reg <= identity_idx();
      end else begin
        if (sel && cfg_tt_we)  tt_reg  <= cfg_tt;
        if (sel && cfg_idx_we) idx_reg <= cfg_idx;
      end
    end
  end

  lnet_addr_gather #(.IN_W(IN_W)) u_gather (
    .vec  (vec_reg),
    .idx  (idx_rd[cur_n]),
    .addr (addr)
  );

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !cfg_any;
        if (in_valid && !cfg_any) state_next = EVAL;
      end
      // The extra cycle at cnt == N_NEUR drains the registered table read.
      EVAL:    if (cnt_reg == CNT_W'(N_NEUR)) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      vec_reg      <= '0;
      cnt_reg      <= '0;
      rd_bit_reg   <= 1'b0;
      rd_v_reg     <= 1'b0;
      rd_n_reg     <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        vec_reg <= in_data;
        cnt_reg <= '0;
      end else if (eval_step) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      rd_v_reg <= eval_step;
      if (eval_step) begin
        rd_bit_reg <= tt_rd[cur_n][addr];
        rd_n_reg   <= cur_n;
      end
      if (rd_v_reg) out_data_reg[rd_n_reg] <= rd_bit_reg;
    end
  end
endmodule

// File: tb/tb_lnet_layer_sched.sv
// Directed bench for lnet_layer_sched: defaults, table/index programming,
// dropped config while busy, config priority, backpressure and async reset.
module tb_lnet_layer_sched;
  import lnet_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        cfg_tt_we, cfg_idx_we;
  logic [4:0]  cfg_neur;
  logic [63:0] cfg_tt;
  logic [29:0] cfg_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  lnet_layer_sched #(.IN_W(32), .N_NEUR(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_tt_we  (cfg_tt_we),
    .cfg_idx_we (cfg_idx_we),
    .cfg_neur   (cfg_neur),
    .cfg_tt     (cfg_tt),
    .cfg_idx    (cfg_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [4:0] n, input logic [63:0] tt, input logic [29:0] idx,
                     input logic twe, input logic iwe);
    @(negedge clk);
    cfg_neur = n; cfg_tt = tt; cfg_idx = idx; cfg_tt_we = twe; cfg_idx_we = iwe;
    @(negedge clk);
    cfg_tt_we = 1'b0; cfg_idx_we = 1'b0;
    $display("cfg neur=%0d tt_we=%0b idx_we=%0b tt=%h idx=%h", n, twe, iwe, tt, idx);
  endtask

  // Present a vector and return just after the edge that accepts it.
  task automatic accept(input logic [31:0] d);
    int n;
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid; `start` edges already passed.
  task automatic wait_out(input int start);
    int n;
    n = start;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("latency", n, 33);
  endtask

  task automatic collect(input logic [31:0] exp);
    check("out_data", out_data, exp);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    $display("result out_data=%h expected=%h", out_data, exp);
  endtask

  task automatic run(input logic [31:0] d, input logic [31:0] exp);
    accept(d);
    wait_out(0);
    collect(exp);
  endtask

  initial begin
    logic [29:0] iv;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_tt_we = 1'b0; cfg_idx_we = 1'b0; cfg_neur = '0; cfg_tt = '0; cfg_idx = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset defaults
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    run(32'hFFFF_FFFF, 32'h0);

    // 2: AND6 on neuron 0, NOR6 on neuron 1, identity fan-in
    cfg(5'd0, 64'h8000_0000_0000_0000, '0, 1'b1, 1'b0);
    cfg(5'd1, 64'h0000_0000_0000_0001, '0, 1'b1, 1'b0);
    run(32'h0000_003F, 32'h0000_0001);
    run(32'h0000_0000, 32'h0000_0002);

    // 3: neuron 5 remapped to inputs 31..26, table copies address bit 0
    for (int j = 0; j < 6; j++) iv[j*5 +: 5] = 5'(31 - j);
    cfg(5'd5, 64'hAAAA_AAAA_AAAA_AAAA, iv, 1'b1, 1'b1);
    run(32'h8000_0000, 32'h0000_0022);
    run(32'h7FFF_FFFF, 32'h0000_0001);

    // 4: table write during EVAL must be dropped
    accept(32'h0000_003F);
    repeat (4) @(negedge clk);
    check("eval_busy", busy, 1);
    cfg_neur = 5'd0; cfg_tt = '0; cfg_tt_we = 1'b1;
    @(posedge clk); #1; cfg_tt_we = 1'b0;
    wait_out(4);
    collect(32'h0000_0001);
    run(32'h0000_003F, 32'h0000_0001);

    // 5: config beats in_valid in the same idle cycle
    @(negedge clk);
    cfg_neur = 5'd2; cfg_tt = '1; cfg_tt_we = 1'b1; in_data = 32'h0; in_valid = 1'b1;
    #1 check("cfg_prio_in_ready", in_ready, 0);
    @(posedge clk); #1; cfg_tt_we = 1'b0;
    check("cfg_prio_not_busy", busy, 0);
    @(negedge clk);
    check("cfg_prio_ready_next", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    check("cfg_prio_accepted", busy, 1);
    wait_out(0);
    collect(32'h0000_0006);

    // 6a: backpressure holds the result
    accept(32'h0000_0000);
    wait_out(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 32'h0000_0006);
      check("bp_in_ready", in_ready, 0);
    end
    collect(32'h0000_0006);

    // 6b: async reset mid-EVAL discards everything
    accept(32'h0000_003F);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_out_data", out_data, 0);
    @(negedge clk); rst_n = 1'b1;
    $display("async reset applied mid-EVAL");
    run(32'h0000_003F, 32'h0000_0000);
    run(32'h0000_0000, 32'h0000_0000);
    run(32'h8000_0000, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
